// File: rtl/spart_pkg.sv
`default_nettype none
// ============================================================================
//  Package     : spart_pkg
//  Description : Shared constants and FSM state encoding for the SPART
//                frame transmitter and its gap timer.
//  Revision    : 1.0 - initial release
// ============================================================================
package spart_pkg;

  // Width of one SPART data byte.
  localparam int BYTE_W = 8;

  // Width of the completed-frame counter.
  localparam int FCNT_W = 16;

  // Transmitter FSM states, 3-bit encoded.
  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_WAIT_TBR = 3'd1,
    S_WRITE    = 3'd2,
    S_SETTLE   = 3'd3,
    S_GAP      = 3'd4
  } state_t;

endpackage : spart_pkg
`default_nettype wire

// File: rtl/spart_frame_tx_if.sv
`default_nettype none
// ============================================================================
//  Interface   : spart_frame_tx_if
//  Description : Byte-write handshake between the frame transmitter (master)
//                and the SPART transmit buffer (slave).
//  Revision    : 1.0 - initial release
// ============================================================================
interface spart_frame_tx_if;
  import spart_pkg::*;

  logic              tbr;      // transmit buffer ready
  logic              tx_we;    // one-cycle write strobe
  logic [BYTE_W-1:0] tx_byte;  // byte presented with tx_we

  modport master (
    input  tbr,
    output tx_we,
    output tx_byte
  );

  modport slave (
    output tbr,
    input  tx_we,
    input  tx_byte
  );

endinterface : spart_frame_tx_if
`default_nettype wire

// File: rtl/counter_x.sv
`default_nettype none
// ============================================================================
//  Module      : counter_x
//  Description : Up-counter that raises full on its COUNT-th enabled cycle
//                after cnt_rst. Used as the inter-frame gap timer.
//  Revision    : 1.0 - initial release
// ============================================================================
module counter_x #(
  parameter int COUNT = 4
) (
  input  wire logic clk,
  input  wire logic rst_n,
  input  wire logic cnt_rst,
  input  wire logic en,
  output logic      full
);

  localparam int          CNT_W = $clog2(COUNT + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(COUNT - 1);

  logic [CNT_W-1:0] cnt;

  // Count enabled cycles from zero, holding once the last count is reached.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (cnt_rst) begin
      cnt <= '0;
    end else if (en && (cnt != LAST)) begin
      cnt <= cnt + 1'b1;
    end
  end

  // full marks the final enabled cycle of the interval.
  always_comb begin
    full = en && (cnt == LAST);
  end

endmodule : counter_x
`default_nettype wire

// File: rtl/spart_frame_tx.sv
`default_nettype none
// ============================================================================
//  Module      : spart_frame_tx
//  Description : Serialises an N-byte frame into the SPART byte-write port
//                against the tbr handshake, with byte ordering, repeat count,
//                continuous mode, stop request, inter-frame gap and a
//                saturating completed-frame counter. All outputs registered.
//  Revision    : 1.0 - initial release
// ============================================================================
module spart_frame_tx
  import spart_pkg::*;
#(
  parameter int NUM_BYTES  = 3,
  parameter int GAP_CYCLES = 1023,
  parameter int MSB_FIRST  = 1,
  parameter int REPEAT     = 1
) (
  input  wire logic                        clk,
  input  wire logic                        rst_n,
  input  wire logic                        start,
  input  wire logic                        stop,
  input  wire logic [BYTE_W*NUM_BYTES-1:0] frame_data,
  spart_frame_tx_if.master                 spart,
  output logic                             busy,
  output logic                             done,
  output logic [FCNT_W-1:0]                frames_sent
);

  localparam int FRAME_W = BYTE_W * NUM_BYTES;
  localparam int IDX_W   = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;
  // The gap timer is always present; with no gap it is simply never entered.
  localparam int GAP_CNT = (GAP_CYCLES > 0) ? GAP_CYCLES : 1;

  localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(NUM_BYTES - 1);
  localparam logic [FCNT_W-1:0] FCNT_MAX  = {FCNT_W{1'b1}};
  localparam logic [15:0]       REPEAT_M1 = 16'(REPEAT - 1);

  state_t state, state_nxt;

  logic [FRAME_W-1:0] shadow,    shadow_nxt;
  logic [IDX_W-1:0]   byte_idx,  byte_idx_nxt;
  logic [15:0]        rep_cnt,   rep_cnt_nxt;
  logic               stop_pend, stop_pend_nxt;
  logic               tx_we,     tx_we_nxt;
  logic [BYTE_W-1:0]  tx_byte,   tx_byte_nxt;
  logic               busy_nxt;
  logic               done_nxt;
  logic [FCNT_W-1:0]  frames_nxt;

  logic               gap_start;
  logic               gap_full;
  logic [BYTE_W-1:0]  sel_byte;

  assign spart.tx_we   = tx_we;
  assign spart.tx_byte = tx_byte;

  // Pick the byte at byte_idx out of the shadow frame in transmit order.
  always_comb begin
    int sel;
    sel = 0;
    if (MSB_FIRST != 0) begin
      sel = NUM_BYTES - 1 - int'(byte_idx);
    end else begin
      sel = int'(byte_idx);
    end
    sel_byte = shadow[sel*BYTE_W +: BYTE_W];
  end

  // Inter-frame gap timer, restarted on every entry into GAP.
  counter_x #(
    .COUNT (GAP_CNT)
  ) u_gap_cnt (
    .clk     (clk),
    .rst_n   (rst_n),
    .cnt_rst (gap_start),
    .en      (state == S_GAP),
    .full    (gap_full)
  );

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and next-value logic for the FSM and all registered outputs.
  always_comb begin
    state_nxt     = state;
    shadow_nxt    = shadow;
    byte_idx_nxt  = byte_idx;
    rep_cnt_nxt   = rep_cnt;
    stop_pend_nxt = stop_pend;
    tx_we_nxt     = 1'b0;
    tx_byte_nxt   = tx_byte;
    busy_nxt      = busy;
    done_nxt      = 1'b0;
    frames_nxt    = frames_sent;
    gap_start     = 1'b0;

    // A stop seen anywhere in a run is remembered until the frame ends.
    if ((state != S_IDLE) && stop) begin
      stop_pend_nxt = 1'b1;
    end

    case (state)
      S_IDLE: begin
        if (start) begin
          shadow_nxt    = frame_data;
          byte_idx_nxt  = '0;
          rep_cnt_nxt   = '0;
          stop_pend_nxt = 1'b0;
          busy_nxt      = 1'b1;
          state_nxt     = S_WAIT_TBR;
        end
      end

      S_WAIT_TBR: begin
        if (spart.tbr) begin
          tx_byte_nxt = sel_byte;
          tx_we_nxt   = 1'b1;
          state_nxt   = S_WRITE;
        end
      end

      S_WRITE: begin
        state_nxt = S_SETTLE;
      end

      // tbr is not looked at here: the SPART needs a cycle to drop it.
      S_SETTLE: begin
        if (byte_idx != LAST_IDX) begin
          byte_idx_nxt = byte_idx + 1'b1;
          state_nxt    = S_WAIT_TBR;
        end else begin
          byte_idx_nxt = '0;
          rep_cnt_nxt  = rep_cnt + 1'b1;
          if (frames_sent != FCNT_MAX) begin
            frames_nxt = frames_sent + 1'b1;
          end
          if (stop_pend || stop || ((REPEAT != 0) && (rep_cnt == REPEAT_M1))) begin
            done_nxt  = 1'b1;
            busy_nxt  = 1'b0;
            state_nxt = S_IDLE;
          end else if (GAP_CYCLES > 0) begin
            gap_start = 1'b1;
            state_nxt = S_GAP;
          end else begin
            state_nxt = S_WAIT_TBR;
          end
        end
      end

      S_GAP: begin
        if (stop || stop_pend) begin
          done_nxt  = 1'b1;
          busy_nxt  = 1'b0;
          state_nxt = S_IDLE;
        end else if (gap_full) begin
          state_nxt = S_WAIT_TBR;
        end
      end

      default: begin
        busy_nxt  = 1'b0;
        state_nxt = S_IDLE;
      end
    endcase
  end

  // Datapath and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow      <= '0;
      byte_idx    <= '0;
      rep_cnt     <= '0;
      stop_pend   <= 1'b0;
      tx_we       <= 1'b0;
      tx_byte     <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      frames_sent <= '0;
    end else begin
      shadow      <= shadow_nxt;
      byte_idx    <= byte_idx_nxt;
      rep_cnt     <= rep_cnt_nxt;
      stop_pend   <= stop_pend_nxt;
      tx_we       <= tx_we_nxt;
      tx_byte     <= tx_byte_nxt;
      busy        <= busy_nxt;
      done        <= done_nxt;
      frames_sent <= frames_nxt;
    end
  end

endmodule : spart_frame_tx
`default_nettype wire
